// File: rtl/lsu_dmem_pkg.sv
// Shared types and helpers for the LSU data memory: funct3 encodings,
// FSM states and the context held across a split access.
package lsu_dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } lsu_state_e;

    // Everything the second half of a word-crossing access needs
    typedef struct packed {
        logic              wren;
        logic [2:0]        funct3;
        logic [1:0]        off;
        logic [WORD_W-1:0] lo_word;
        logic [WORD_W-1:0] hi_wdata;
        logic [3:0]        hi_be;
    } split_ctx_t;

    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic [2:0] funct3);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_dmem_if.sv
// Request/response bus between the core LSU (master) and the data memory (slave).
interface lsu_dmem_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              i_req;
    logic              i_lsu_wren;
    logic [2:0]        i_funct3;
    logic [ADDR_W-1:0] i_data_addr;
    logic [31:0]       i_data;
    logic [31:0]       o_data;
    logic              o_valid;
    logic              o_ready;
    logic              o_misalign;
    logic              o_oob;
    logic              o_illegal;

    modport master (
        output i_req, i_lsu_wren, i_funct3, i_data_addr, i_data,
        input  o_data, o_valid, o_ready, o_misalign, o_oob, o_illegal
    );

    modport slave (
        input  i_req, i_lsu_wren, i_funct3, i_data_addr, i_data,
        output o_data, o_valid, o_ready, o_misalign, o_oob, o_illegal
    );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Byte-lane steering: store data/enables across a word pair, and load
// extraction with sign/zero extension from a little-endian word pair.
module dmem_lane_fmt
    import lsu_dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    input  logic [63:0] ld_pair,
    output logic [63:0] st_lanes,
    output logic [7:0]  st_be,
    output logic [31:0] ld_data
);
    logic [4:0]  shamt;
    logic [3:0]  mask;
    logic [31:0] raw;

    always_comb begin
        shamt    = {off, 3'b000};
        st_lanes = 64'(st_data) << shamt;
        case (size_bytes(funct3))
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        st_be = 8'(mask) << off;
        raw   = 32'(ld_pair >> shamt);
        case (funct3)
            F3_B:    ld_data = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   ld_data = {24'h0, raw[7:0]};
            F3_H:    ld_data = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   ld_data = {16'h0, raw[15:0]};
            default: ld_data = raw;
        endcase
    end
endmodule

// File: rtl/lsu_dmem.sv
// Windowed data memory with B/H/W access, sign/zero extension, error
// checks, and optional two-cycle split of word-crossing accesses.
module lsu_dmem
    import lsu_dmem_pkg::*;
#(
    parameter int unsigned       ADDR_W           = 16,
    parameter int unsigned       DEPTH_WORDS      = 2048,
    parameter logic [ADDR_W-1:0] BASE_ADDR        = ADDR_W'(16'h2000),
    parameter bit                SPLIT_MISALIGNED = 1'b1
) (
    input  logic     i_clk,
    input  logic     i_rst,
    lsu_dmem_if.slave bus
);
    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam int unsigned EW        = ADDR_W + 2;
    localparam int unsigned WIN_BYTES = 4 * DEPTH_WORDS;

    logic [31:0] mem [DEPTH_WORDS];

    lsu_state_e       st_q, st_d;
    split_ctx_t       ctx_q, ctx_d;
    logic [IDX_W-1:0] idx_hi_q, idx_hi_d;
    logic             valid_q, valid_d, ready_q;
    logic             mis_q, mis_d, oob_q, oob_d, ill_q, ill_d;
    logic [31:0]      data_q, data_d;

    logic [2:0]        size;
    logic [ADDR_W-1:0] rel;
    logic [1:0]        off;
    logic [IDX_W-1:0]  idx;
    logic [EW-1:0]     first_b, last_b;
    logic              illegal, oob, trap_mis, is_cross, err, accept, go_split;
    logic              we_lo, we_hi;

    // Request decode and error classification
    always_comb begin
        size     = size_bytes(bus.i_funct3);
        rel      = bus.i_data_addr - BASE_ADDR;
        off      = rel[1:0];
        idx      = IDX_W'(rel >> 2);
        first_b  = EW'(bus.i_data_addr);
        last_b   = first_b + EW'(size) - EW'(1);
        illegal  = !f3_legal(bus.i_funct3) || (bus.i_lsu_wren && bus.i_funct3[2]);
        oob      = (first_b < EW'(BASE_ADDR)) ||
                   (last_b >= EW'(BASE_ADDR) + EW'(WIN_BYTES));
        is_cross = (3'(off) + size) > 3'd4;
        trap_mis = !SPLIT_MISALIGNED &&
                   (((size == 3'd2) && off[0]) || ((size == 3'd4) && (off != 2'd0)));
        err      = illegal || oob || trap_mis;
        accept   = bus.i_req && (st_q == ST_IDLE);
        go_split = accept && !err && is_cross;
        we_lo    = accept && bus.i_lsu_wren && !err;
        we_hi    = (st_q == ST_SPLIT) && ctx_q.wren;
    end

    logic [31:0] rd_lo, rd_hi, ld_data;
    logic [2:0]  fmt_f3;
    logic [1:0]  fmt_off;
    logic [63:0] fmt_pair, lanes;
    logic [7:0]  be;

    assign rd_lo = mem[idx];
    assign rd_hi = mem[idx_hi_q];

    // In SPLIT the formatter works on the latched access and the stored low word
    always_comb begin
        if (st_q == ST_SPLIT) begin
            fmt_f3   = ctx_q.funct3;
            fmt_off  = ctx_q.off;
            fmt_pair = {rd_hi, ctx_q.lo_word};
        end else begin
            fmt_f3   = bus.i_funct3;
            fmt_off  = off;
            fmt_pair = {32'h0, rd_lo};
        end
    end

    dmem_lane_fmt u_fmt (
        .funct3   (fmt_f3),
        .off      (fmt_off),
        .st_data  (bus.i_data),
        .ld_pair  (fmt_pair),
        .st_lanes (lanes),
        .st_be    (be),
        .ld_data  (ld_data)
    );

    always_ff @(posedge i_clk) begin : mem_wr
        for (int b = 0; b < 4; b++) begin
            if (we_lo && be[b])
                mem[idx][8*b +: 8] <= lanes[8*b +: 8];
            if (we_hi && ctx_q.hi_be[b])
                mem[idx_hi_q][8*b +: 8] <= ctx_q.hi_wdata[8*b +: 8];
        end
    end

    // Next state and response
    always_comb begin
        st_d     = st_q;
        ctx_d    = ctx_q;
        idx_hi_d = idx_hi_q;
        valid_d  = 1'b0;
        mis_d    = 1'b0;
        oob_d    = 1'b0;
        ill_d    = 1'b0;
        data_d   = 32'h0;
        case (st_q)
            ST_IDLE: begin
                if (go_split) begin
                    st_d           = ST_SPLIT;
                    idx_hi_d       = idx + IDX_W'(1);
                    ctx_d.wren     = bus.i_lsu_wren;
                    ctx_d.funct3   = bus.i_funct3;
                    ctx_d.off      = off;
                    ctx_d.lo_word  = rd_lo;
                    ctx_d.hi_wdata = lanes[63:32];
                    ctx_d.hi_be    = be[7:4];
                end else if (accept) begin
                    valid_d = 1'b1;
                    ill_d   = illegal;
                    oob_d   = !illegal && oob;
                    mis_d   = !illegal && !oob && trap_mis;
                    if (!err && !bus.i_lsu_wren)
                        data_d = ld_data;
                end
            end
            ST_SPLIT: begin
                st_d    = ST_IDLE;
                valid_d = 1'b1;
                if (!ctx_q.wren)
                    data_d = ld_data;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_q     <= ST_IDLE;
            ctx_q    <= '0;
            idx_hi_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            mis_q    <= 1'b0;
            oob_q    <= 1'b0;
            ill_q    <= 1'b0;
            data_q   <= 32'h0;
        end else begin
            st_q     <= st_d;
            ctx_q    <= ctx_d;
            idx_hi_q <= idx_hi_d;
            valid_q  <= valid_d;
            ready_q  <= (st_d == ST_IDLE);
            mis_q    <= mis_d;
            oob_q    <= oob_d;
            ill_q    <= ill_d;
            data_q   <= data_d;
        end
    end

    assign bus.o_data     = data_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_ready    = ready_q;
    assign bus.o_misalign = mis_q;
    assign bus.o_oob      = oob_q;
    assign bus.o_illegal  = ill_q;

endmodule

// File: doc/lsu_dmem.md
Name: lsu_dmem

Overview:
Parametrised successor to the single-port data memory. It adds byte, halfword and word loads/stores with sign/zero extension, and an address window check. Misaligned accesses are either trapped or split into two word accesses, depending on a parameter. It sits behind the LSU of the single-cycle core and supplies load data one cycle after a request is accepted; o_ready stalls the core.

Parameters:
ADDR_W, 16, byte-address width
DEPTH_WORDS, 2048, number of 32-bit words of storage (power of 2)
BASE_ADDR, 16'h2000, first byte address of the window
SPLIT_MISALIGNED, 1, 1 = split word-crossing accesses over two cycles; 0 = trap every non-natural alignment

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_req  in  1  access request, accepted when i_req && o_ready
i_lsu_wren  in  1  1 = store, 0 = load
i_funct3  in  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_data_addr  in  ADDR_W  byte address
i_data  in  32  store data, right-justified
o_data  out  32  load result, extended per funct3; 0 for stores and errors
o_valid  out  1  one-cycle pulse marking completion of an accepted access
o_ready  out  1  0 while the second half of a split access is in flight
o_misalign  out  1  valid with o_valid: trapped misaligned access
o_oob  out  1  valid with o_valid: access outside the window
o_illegal  out  1  valid with o_valid: funct3 not in {000,001,010,100,101}, or 1xx on a store

Behaviour:
- Reset (async, i_rst=1):
  - FSM goes to IDLE.
  - o_valid, o_misalign, o_oob, o_illegal and o_data go to 0; o_ready goes to 1.
  - Memory contents are not cleared.
- FSM states:
  - IDLE: o_ready=1.
  - SPLIT: o_ready=0. Latched address, data, size and second-word byte enables are held here.
- Aligned or non-crossing access:
  - An unaligned halfword at offset 1 does not cross a word and counts as non-crossing.
  - Accepted in IDLE. Store bytes are written on that clock edge via byte enables.
  - Load word is read synchronously. On the next cycle o_valid=1, and o_data is the extracted bytes, shifted and sign- or zero-extended.
  - Back-to-back requests are allowed every cycle.
- Crossing access (word offset 1-3, or halfword offset 3):
  - SPLIT_MISALIGNED=1:
    - Cycle 0 (IDLE): write/read the low word, go to SPLIT.
    - Cycle 1 (SPLIT): write/read word+1, go to IDLE.
    - Cycle 2: o_valid=1, with o_data assembled little-endian from both words.
    - Total latency 2. Requests during SPLIT are ignored; the requester holds them.
  - SPLIT_MISALIGNED=0: any non-natural alignment (H at odd address, W at non-multiple of 4) writes nothing. The next cycle gives o_valid=1, o_misalign=1, o_data=0.
- Window check:
  - The first and last byte addresses must both lie in [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS-1].
  - A failing access writes nothing, is never split, and gives o_valid=1, o_oob=1, o_data=0 next cycle.
  - Word index wraps nowhere; a split at the top word is an oob error.
- Error priority: illegal > oob > misalign. An errored access never writes.
- Store then load of the same address in the next cycle returns the new data; no read-during-write in the same cycle.
- Reset during SPLIT: the first half remains written, the second half is dropped, and no o_valid is produced.

Decomposition:
- Package lsu_dmem_pkg holds:
  - funct3 constants F3_B/H/W/BU/HU
  - state enum {ST_IDLE, ST_SPLIT}
  - function size_bytes(funct3)
- Sub-module dmem_lane_fmt (combinational) does:
  - store data to byte lanes plus 8-bit enables across two words
  - load extraction/extension from a 64-bit word pair
- Top level holds the storage array, FSM and checks.

Test Plan:
- SW 0x2000=DEADBEEF; LW 0x2000 -> o_data DEADBEEF, o_valid one cycle after accept; LB 0x2003 -> FFFFFFDE; LBU 0x2003 -> 000000DE; LH 0x2002 -> FFFFDEAD.
- SB 0x2004=0x5A over 12345678 at 0x2004 -> LW 0x2004 = 1234565A; SH 0x2006=ABCD -> ABCD565A.
- SPLIT=1: SW 0x2009=CAFEBABE -> o_ready low one cycle; LW 0x2008 = FEBABExx (xx is the unmodified low byte); LW 0x200C low byte = CA; LW 0x2009 -> CAFEBABE at latency 2.
- SPLIT=0: LW 0x2002 -> o_misalign=1, o_data=0, memory unchanged.
- LW 0x1FFC and SW 0x2000+4*DEPTH_WORDS-2 (word) -> o_oob=1, no write; funct3=011 -> o_illegal=1.
- Assert i_rst in SPLIT of SW 0x2009=11223344 -> o_valid stays 0, o_ready=1; word 0x200C unchanged, word 0x2008 upper bytes = 223344.
